// File: rtl/riscv_pkg.sv
// Shared core definitions: register-file geometry and write-port source tags.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_LU
    } wr_src_e;

    // x0 is hardwired, so writes/issues targeting it carry no effect
    function automatic logic is_live(input reg_addr_t rd);
        return rd != REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for registers awaiting a long-latency write.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREG_P = NREG
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      set_en,
    input  reg_addr_t set_rd,
    input  logic      clr_en,
    input  reg_addr_t clr_rd,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    input  reg_addr_t rd,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic      rd_busy,
    output logic      dbl_issue
);

    logic [NREG_P-1:0] busy_q;
    logic [NREG_P-1:0] busy_d;

    // clear first so a same-cycle reissue of the register wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en)
            busy_d[clr_rd] = 1'b0;
        if (set_en && is_live(set_rd))
            busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign rs1_busy  = busy_q[rs1];
    assign rs2_busy  = busy_q[rs2];
    assign rd_busy   = busy_q[rd];
    assign dbl_issue = set_en && is_live(set_rd) && busy_q[set_rd];

endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write-port arbiter (WB vs long-latency unit) with hazard
// scoreboard and a starvation guard that requests WB bubbles.
module regfile_wr_sched
    import riscv_pkg::*;
#(
    parameter int XLEN_P   = XLEN,
    parameter int NREG_P   = NREG,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  reg_addr_t         wb_rd,
    input  logic [XLEN_P-1:0] wb_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  reg_addr_t         lu_rd,
    input  logic [XLEN_P-1:0] lu_data,
    input  logic              iss_valid,
    input  reg_addr_t         iss_rd,
    input  reg_addr_t         dec_rs1,
    input  logic              dec_rs1_en,
    input  reg_addr_t         dec_rs2,
    input  logic              dec_rs2_en,
    input  reg_addr_t         dec_rd,
    input  logic              dec_rd_en,
    output logic              hz_stall,
    output logic              wb_hold,
    output logic              rf_wen,
    output reg_addr_t         rf_rd,
    output logic [XLEN_P-1:0] rf_wd,
    output logic              proto_err
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT - 1);

    logic          wb_act;
    logic          lu_hs;
    logic          blocked;
    wr_src_e       src;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] cnt_d;
    logic          hold_d;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          rd_busy;
    logic          dbl_issue;

    assign wb_act   = wb_valid && is_live(wb_rd);
    assign lu_ready = !wb_act;
    assign lu_hs    = lu_valid && lu_ready;
    assign blocked  = lu_valid && !lu_ready;

    always_comb begin
        src = SRC_NONE;
        if (wb_act)
            src = SRC_WB;
        else if (lu_hs && is_live(lu_rd))
            src = SRC_LU;
    end

    always_comb begin
        rf_wen = 1'b0;
        rf_rd  = REG_ZERO;
        rf_wd  = '0;
        unique case (src)
            SRC_WB: begin
                rf_wen = 1'b1;
                rf_rd  = wb_rd;
                rf_wd  = wb_data;
            end
            SRC_LU: begin
                rf_wen = 1'b1;
                rf_rd  = lu_rd;
                rf_wd  = lu_data;
            end
            default: ;
        endcase
    end

    reg_scoreboard #(
        .NREG_P (NREG_P)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (iss_valid),
        .set_rd    (iss_rd),
        .clr_en    (lu_hs),
        .clr_rd    (lu_rd),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .rd        (dec_rd),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rd_busy   (rd_busy),
        .dbl_issue (dbl_issue)
    );

    assign hz_stall = (dec_rs1_en && rs1_busy)
                    | (dec_rs2_en && rs2_busy)
                    | (dec_rd_en  && rd_busy);

    // a WB that ignores the hold keeps the hold asserted
    always_comb begin
        cnt_d  = '0;
        hold_d = wb_hold;
        if (blocked)
            cnt_d = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
        if (blocked && wait_cnt == CNT_MAX)
            hold_d = 1'b1;
        else if (wb_act && wb_hold)
            hold_d = 1'b1;
        else if (lu_hs || !lu_valid)
            hold_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            wb_hold   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            wait_cnt  <= cnt_d;
            wb_hold   <= hold_d;
            proto_err <= proto_err | dbl_issue | (wb_act & wb_hold);
        end
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched with a cycle-level reference model.
module tb_regfile_wr_sched;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  dec_rs1;
    logic        dec_rs1_en;
    logic [4:0]  dec_rs2;
    logic        dec_rs2_en;
    logic [4:0]  dec_rd;
    logic        dec_rd_en;
    logic        hz_stall;
    logic        wb_hold;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    regfile_wr_sched #(.MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .dec_rs1    (dec_rs1),
        .dec_rs1_en (dec_rs1_en),
        .dec_rs2    (dec_rs2),
        .dec_rs2_en (dec_rs2_en),
        .dec_rd     (dec_rd),
        .dec_rd_en  (dec_rd_en),
        .hz_stall   (hz_stall),
        .wb_hold    (wb_hold),
        .rf_wen     (rf_wen),
        .rf_rd      (rf_rd),
        .rf_wd      (rf_wd),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // reference model: pending LU destinations, blocked-run length, flags
    bit mbusy [32];
    int mrun;
    bit mhold;
    bit merr;
    bit m_wa;
    bit m_hs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            mrun  = 0;
            mhold = 1'b0;
            merr  = 1'b0;
        end else begin
            m_wa = wb_valid && (wb_rd != 0);
            m_hs = lu_valid && !m_wa;
            if (iss_valid && iss_rd != 0 && mbusy[iss_rd]) merr = 1'b1;
            if (m_wa && mhold) merr = 1'b1;
            if (lu_valid && m_wa) begin
                mrun++;
                if (mrun >= MAXW) mhold = 1'b1;
            end else begin
                mrun = 0;
                if (!(m_wa && mhold)) mhold = 1'b0;
            end
            if (m_hs) mbusy[lu_rd] = 1'b0;
            if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1'b1;
        end
    end

    bit          c_wa;
    bit          e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    bit          e_hz;

    always @(negedge clk) begin
        if (!rst) begin
            c_wa  = wb_valid && (wb_rd != 0);
            e_wen = 1'b0;
            e_rd  = 5'd0;
            e_wd  = 32'd0;
            if (c_wa) begin
                e_wen = 1'b1;
                e_rd  = wb_rd;
                e_wd  = wb_data;
            end else if (lu_valid && lu_rd != 0) begin
                e_wen = 1'b1;
                e_rd  = lu_rd;
                e_wd  = lu_data;
            end
            e_hz = (dec_rs1_en && mbusy[dec_rs1])
                 || (dec_rs2_en && mbusy[dec_rs2])
                 || (dec_rd_en && mbusy[dec_rd]);
            chk("m_lu_ready", 32'(lu_ready), 32'(!c_wa));
            chk("m_rf_wen", 32'(rf_wen), 32'(e_wen));
            chk("m_rf_rd", 32'(rf_rd), 32'(e_rd));
            chk("m_rf_wd", rf_wd, e_wd);
            chk("m_hz_stall", 32'(hz_stall), 32'(e_hz));
            chk("m_wb_hold", 32'(wb_hold), 32'(mhold));
            chk("m_proto_err", 32'(proto_err), 32'(merr));
        end
    end

    task automatic idle();
        wb_valid   = 0; wb_rd  = 0; wb_data = 0;
        lu_valid   = 0; lu_rd  = 0; lu_data = 0;
        iss_valid  = 0; iss_rd = 0;
        dec_rs1    = 0; dec_rs1_en = 0;
        dec_rs2    = 0; dec_rs2_en = 0;
        dec_rd     = 0; dec_rd_en  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset / idle
        #1;
        chk("rst_wen", 32'(rf_wen), 0);
        chk("rst_ready", 32'(lu_ready), 1);
        chk("rst_hz", 32'(hz_stall), 0);
        chk("rst_hold", 32'(wb_hold), 0);
        chk("rst_err", 32'(proto_err), 0);
        tick();

        // port conflict
        wb_valid = 1; wb_rd = 3; wb_data = 32'hAA;
        lu_valid = 1; lu_rd = 5; lu_data = 32'hBB;
        #1;
        chk("conf_rd", 32'(rf_rd), 3);
        chk("conf_wd", rf_wd, 32'hAA);
        chk("conf_ready", 32'(lu_ready), 0);
        tick();
        wb_valid = 0; wb_rd = 0;
        #1;
        chk("conf_lu_rd", 32'(rf_rd), 5);
        chk("conf_lu_wd", rf_wd, 32'hBB);
        chk("conf_lu_ready", 32'(lu_ready), 1);
        tick();
        idle();

        // RAW hazard on x7
        iss_valid = 1; iss_rd = 7;
        dec_rs1 = 7; dec_rs1_en = 1;
        #1 chk("hz_same_cycle", 32'(hz_stall), 0);
        tick();
        iss_valid = 0;
        #1 chk("hz_set", 32'(hz_stall), 1);
        tick();
        #1 chk("hz_hold", 32'(hz_stall), 1);
        lu_valid = 1; lu_rd = 7; lu_data = 32'h77;
        #1;
        chk("hz_wr_cycle", 32'(hz_stall), 1);
        chk("hz_wr_rd", 32'(rf_rd), 7);
        tick();
        lu_valid = 0;
        #1 chk("hz_clear", 32'(hz_stall), 0);
        tick();
        idle();

        // WAW and rs2 lookups on x12
        iss_valid = 1; iss_rd = 12;
        tick();
        iss_valid = 0;
        dec_rd = 12; dec_rd_en = 1;
        #1 chk("waw_rd", 32'(hz_stall), 1);
        dec_rd_en = 0; dec_rs2 = 12; dec_rs2_en = 1;
        #1 chk("raw_rs2", 32'(hz_stall), 1);
        lu_valid = 1; lu_rd = 12; lu_data = 32'h12;
        tick();
        idle();
        dec_rs2 = 12; dec_rs2_en = 1;
        #1 chk("rs2_clear", 32'(hz_stall), 0);
        tick();
        idle();

        // x0 cases
        wb_valid = 1; wb_rd = 0; wb_data = 32'h5;
        lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
        iss_valid = 1; iss_rd = 0;
        #1;
        chk("x0_ready", 32'(lu_ready), 1);
        chk("x0_lu_rd", 32'(rf_rd), 9);
        tick();
        idle();
        dec_rs1 = 0; dec_rs1_en = 1;
        #1 chk("x0_no_stall", 32'(hz_stall), 0);
        tick();
        idle();

        // starvation, pipeline honours the hold
        lu_valid = 1; lu_rd = 10; lu_data = 32'h1010;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1; wb_rd = 5'(i + 1); wb_data = 32'(i);
            #1 chk("starve_nohold", 32'(wb_hold), 0);
            tick();
        end
        wb_valid = 0; wb_rd = 0;
        #1;
        chk("starve_hold", 32'(wb_hold), 1);
        chk("starve_lu_rd", 32'(rf_rd), 10);
        tick();
        lu_valid = 0;
        #1;
        chk("starve_release", 32'(wb_hold), 0);
        chk("starve_noerr", 32'(proto_err), 0);
        tick();
        idle();

        // starvation with WB ignoring the hold, then async reset
        lu_valid = 1; lu_rd = 11; lu_data = 32'h11;
        wb_valid = 1; wb_rd = 2; wb_data = 32'h22;
        iss_valid = 1; iss_rd = 20;
        tick();
        iss_valid = 0;
        dec_rs1 = 20; dec_rs1_en = 1;
        repeat (3) tick();
        #1;
        chk("viol_hold", 32'(wb_hold), 1);
        chk("viol_pre_err", 32'(proto_err), 0);
        tick();
        #1;
        chk("viol_err", 32'(proto_err), 1);
        chk("viol_hold_kept", 32'(wb_hold), 1);
        chk("viol_hz", 32'(hz_stall), 1);
        rst = 1'b1;
        #1;
        chk("arst_hold", 32'(wb_hold), 0);
        chk("arst_err", 32'(proto_err), 0);
        chk("arst_hz", 32'(hz_stall), 0);
        idle();
        tick();
        rst = 1'b0;
        tick();

        // double issue
        iss_valid = 1; iss_rd = 4;
        tick();
        #1 chk("dbl_pre", 32'(proto_err), 0);
        tick();
        iss_valid = 0;
        dec_rs1 = 4; dec_rs1_en = 1;
        #1;
        chk("dbl_err", 32'(proto_err), 1);
        chk("dbl_busy", 32'(hz_stall), 1);
        lu_valid = 1; lu_rd = 4; lu_data = 32'h44;
        tick();
        idle();
        dec_rs1 = 4; dec_rs1_en = 1;
        #1 chk("dbl_cleared", 32'(hz_stall), 0);
        tick();
        idle();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
